cell_pos_fetch: RTL and testbench
=================================

CELL_POS_FETCH -- requirements
Module: cell_pos_fetch

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 96, width of one {posz, posy, posx} word.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, cell memory address width.
REQ-003 SHALL have parameter PARTICLE_NUM, default 220, cell memory depth including address 0.
REQ-004 SHALL have one clock and a synchronous, active-high reset: clk  in  1  sole clock; rst  in  1  synchronous active-high reset.
REQ-005 SHALL have ports:
- start  in  1  begin one cell sweep.
- busy  out  1  sweep in progress.
- done  out  1  one-cycle pulse at sweep end.
- mem_addr  out  ADDR_WIDTH  cell memory address.
- mem_rden  out  1  cell memory read enable.
- mem_q  in  DATA_WIDTH  cell memory data, valid 2 cycles after the mem_rden cycle.
- out_pos  out  DATA_WIDTH  particle position.
- out_pid  out  ADDR_WIDTH  particle address, 1..N.
- out_valid  out  1  out_pos, out_pid and out_last valid.
- out_ready  in  1  consumer accepts.
- out_last  out  1  marks the final particle.
- particle_count  out  ADDR_WIDTH  N latched from address 0.
- count_err  out  1  sticky; stored count exceeded capacity.

Function
REQ-006 SHALL use FSM states IDLE, RD_CNT, WAIT_CNT, STREAM, DRAIN, FINISH.
REQ-007 IDLE: start=1 SHALL go to RD_CNT; start while not IDLE SHALL be ignored.
REQ-008 RD_CNT SHALL drive mem_addr=0 and mem_rden=1 for one cycle, then go to WAIT_CNT.
REQ-009 WAIT_CNT SHALL hold 2 cycles, then latch N = mem_q[ADDR_WIDTH-1:0] into particle_count.
REQ-010 If N > PARTICLE_NUM-1, SHALL clamp N to PARTICLE_NUM-1 and set count_err.
REQ-011 N=0 SHALL go directly to FINISH with no out_valid.
REQ-012 STREAM SHALL issue reads at addresses 1..N in ascending order, at most one per cycle.
REQ-013 A read SHALL issue only when (FIFO occupancy + reads in flight) < 4, so no returned data is ever dropped.
REQ-014 Each returned word SHALL be pushed into a 4-deep FIFO together with its pid and last flag (pid == N).
REQ-015 After issuing address N, SHALL go to DRAIN.
REQ-016 DRAIN SHALL wait until reads in flight = 0 and the FIFO is empty, then go to FINISH.
REQ-017 FINISH SHALL pulse done for one cycle and return to IDLE.
REQ-018 busy SHALL be 1 in every state except IDLE.
REQ-019 out_valid SHALL equal FIFO not-empty; a FIFO pop SHALL occur on out_valid && out_ready.
REQ-020 Output data SHALL stay stable while out_valid=1 and out_ready=0.
REQ-021 With out_ready held at 1, SHALL sustain 1 particle/cycle after an initial latency.
REQ-022 Initial latency SHALL be 7 cycles from the start cycle to the first out_valid.
REQ-023 Simultaneous FIFO push and pop SHALL leave occupancy unchanged.
REQ-024 When mem_rden=0, mem_addr SHALL hold its last value.
REQ-025 count_err SHALL clear only on rst.

Reset
REQ-026 rst SHALL force, on the next clk edge: state IDLE, busy=0, done=0, mem_rden=0, mem_addr=0, out_valid=0, out_last=0, out_pos=0, out_pid=0, particle_count=0, count_err=0, FIFO empty, in-flight count 0.
REQ-027 rst asserted mid-sweep SHALL abort the sweep; data returned after reset SHALL be discarded.

Structure
REQ-028 Read latency (2), FIFO depth (4) and the state encoding SHALL live in the shared MD package/define file beside the existing position-cache constants.
REQ-029 The FIFO SHALL be a sub-module named pos_fetch_fifo, parameterized by width and depth.
REQ-030 SHALL sit between a cell memory instance and the position cache/filter consumer, one instance per cell.

Verification
REQ-031 N=3 with out_ready=1: reads at 0,1,2,3; out_pid sequence 1,2,3; out_last on pid 3; done exactly once; first out_valid 7 cycles after start.
REQ-032 N=0: no out_valid, done pulses, busy returns to 0 without any read beyond address 0.
REQ-033 N=10 with out_ready toggling 1,0,0,1: all 10 pids delivered in order, no duplicates or losses, data stable while stalled, FIFO occupancy never exceeds 4.
REQ-034 Address 0 holds 250, PARTICLE_NUM=220: particle_count=219, count_err=1, 219 particles delivered.
REQ-035 rst asserted during STREAM at pid 5: next cycle all outputs zero; a new start with N=2 delivers exactly pids 1,2.
REQ-036 start asserted while busy: ignored, with a single done for the sweep.

Source files
------------

// File: rtl/cell_pos_fetch_pkg.sv
// Shared constants for the cell position fetch path.
// Holds the cell-memory read latency, the output FIFO depth and the
// sweep FSM state encoding used by cell_pos_fetch.
package cell_pos_fetch_pkg;

  // Cycles from a cell-memory read enable to valid read data.
  localparam int POS_RD_LATENCY = 2;

  // Depth of the per-cell output FIFO.
  localparam int POS_FIFO_DEPTH = 4;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_CNT   = 3'd1,
    WAIT_CNT = 3'd2,
    STREAM   = 3'd3,
    DRAIN    = 3'd4,
    FINISH   = 3'd5
  } pf_state_t;

endpackage

// File: rtl/pos_fetch_fifo.sv
// Small synchronous FIFO used to buffer fetched particle positions.
// Ports:
//   clk, rst   : clock and synchronous active-high reset (pointers/count only)
//   push/wdata : write strobe and data
//   pop/rdata  : read strobe and head-of-queue data (first-word fall-through)
//   empty      : no entries stored
//   count      : current occupancy, 0..DEPTH
module pos_fetch_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [WIDTH-1:0]             wdata,
  input  logic                         pop,
  output logic [WIDTH-1:0]             rdata,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] store [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);
  assign rdata   = store[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) store[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/cell_pos_fetch.sv
// Sweeps one cell memory: reads the particle count at address 0, then
// streams positions from addresses 1..N to a ready/valid consumer through
// a small FIFO. Reads are throttled so every returned word has a FIFO slot.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   start           : begin a sweep (ignored while busy)
//   busy, done      : sweep in progress / one-cycle end-of-sweep pulse
//   mem_addr/rden   : cell memory read port (addr holds when rden=0)
//   mem_q           : read data, valid two cycles after the rden cycle
//   out_pos/pid/last: particle position, address (1..N), final-particle flag
//   out_valid/ready : output handshake
//   particle_count  : N as latched (after clamping)
//   count_err       : sticky, stored count exceeded capacity
module cell_pos_fetch
  import cell_pos_fetch_pkg::*;
#(
  parameter int DATA_WIDTH   = 96,
  parameter int ADDR_WIDTH   = 8,
  parameter int PARTICLE_NUM = 220
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rden,
  input  logic [DATA_WIDTH-1:0] mem_q,
  output logic [DATA_WIDTH-1:0] out_pos,
  output logic [ADDR_WIDTH-1:0] out_pid,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic [ADDR_WIDTH-1:0] particle_count,
  output logic                  count_err
);

  localparam int ENTRY_W = DATA_WIDTH + ADDR_WIDTH + 1;
  localparam int CNT_W   = $clog2(POS_FIFO_DEPTH + 1);
  localparam int OCC_W   = CNT_W + 1;
  localparam int WC_W    = $clog2(POS_RD_LATENCY + 1);
  localparam logic [ADDR_WIDTH-1:0] MAX_N     = ADDR_WIDTH'(PARTICLE_NUM - 1);
  localparam logic [WC_W-1:0]       WAIT_LAST = WC_W'(POS_RD_LATENCY - 1);

  // Returns {overflow, clamped_count}.
  function automatic logic [ADDR_WIDTH:0] clamp_count(input logic [ADDR_WIDTH-1:0] raw);
    if (raw > MAX_N) return {1'b1, MAX_N};
    return {1'b0, raw};
  endfunction

  pf_state_t             state;
  pf_state_t             state_nxt;
  logic [WC_W-1:0]       wait_cnt;
  logic [ADDR_WIDTH-1:0] next_pid;
  logic [ADDR_WIDTH-1:0] addr_hold;
  logic [ADDR_WIDTH:0]   cnt_clamped;
  logic                  rd_issue;
  logic                  data_issue;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [OCC_W-1:0]      occupancy;
  logic                  slot_free;

  logic                  vld_p0, vld_p1;
  logic [ADDR_WIDTH-1:0] pid_p0, pid_p1;
  logic                  last_p0, last_p1;

  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  fifo_empty;
  logic [CNT_W-1:0]      fifo_count;
  logic [ENTRY_W-1:0]    fifo_wdata;
  logic [ENTRY_W-1:0]    fifo_rdata;

  assign cnt_clamped = clamp_count(mem_q[ADDR_WIDTH-1:0]);

  // Words already buffered plus words still coming back from memory; a new
  // read only goes out if all of them together still fit in the FIFO.
  assign occupancy = OCC_W'(fifo_count) + OCC_W'(vld_p0) + OCC_W'(vld_p1);
  assign slot_free = (occupancy < OCC_W'(POS_FIFO_DEPTH));

  always_comb begin
    state_nxt  = state;
    rd_issue   = 1'b0;
    data_issue = 1'b0;
    rd_addr    = next_pid;
    case (state)
      IDLE: begin
        if (start) state_nxt = RD_CNT;
      end
      RD_CNT: begin
        rd_issue  = 1'b1;
        rd_addr   = '0;
        state_nxt = WAIT_CNT;
      end
      WAIT_CNT: begin
        if (wait_cnt == WAIT_LAST)
          state_nxt = (cnt_clamped[ADDR_WIDTH-1:0] == '0) ? FINISH : STREAM;
      end
      STREAM: begin
        if (slot_free) begin
          rd_issue   = 1'b1;
          data_issue = 1'b1;
          if (next_pid == particle_count) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (!vld_p0 && !vld_p1 && fifo_empty) state_nxt = FINISH;
      end
      FINISH: begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      wait_cnt       <= '0;
      next_pid       <= '0;
      addr_hold      <= '0;
      particle_count <= '0;
      count_err      <= 1'b0;
      vld_p0         <= 1'b0;
      vld_p1         <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == RD_CNT) wait_cnt <= '0;
      else if (state == WAIT_CNT) wait_cnt <= wait_cnt + WC_W'(1);
      if (state == WAIT_CNT && wait_cnt == WAIT_LAST) begin
        particle_count <= cnt_clamped[ADDR_WIDTH-1:0];
        count_err      <= count_err | cnt_clamped[ADDR_WIDTH];
        next_pid       <= ADDR_WIDTH'(1);
      end else if (data_issue) begin
        next_pid <= next_pid + ADDR_WIDTH'(1);
      end
      if (rd_issue) addr_hold <= rd_addr;
      vld_p0 <= data_issue;
      vld_p1 <= vld_p0;
    end
  end

  // Stage p0: read issued, memory latching the address
  // Stage p1: memory output register; mem_q is valid in this stage
  always_ff @(posedge clk) begin
    pid_p0  <= rd_addr;
    last_p0 <= (rd_addr == particle_count);
    pid_p1  <= pid_p0;
    last_p1 <= last_p0;
  end

  assign mem_rden = rd_issue;
  assign mem_addr = rd_issue ? rd_addr : addr_hold;
  assign busy     = (state != IDLE);
  assign done     = (state == FINISH);

  assign fifo_push  = vld_p1;
  assign fifo_wdata = {last_p1, pid_p1, mem_q};
  assign fifo_pop   = out_valid && out_ready;

  pos_fetch_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (POS_FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata (fifo_wdata),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Stage out: FIFO head drives the consumer; zeroed while nothing is held
  assign out_valid = !fifo_empty;
  assign out_pos   = out_valid ? fifo_rdata[DATA_WIDTH-1:0] : '0;
  assign out_pid   = out_valid ? fifo_rdata[DATA_WIDTH +: ADDR_WIDTH] : '0;
  assign out_last  = out_valid ? fifo_rdata[ENTRY_W-1] : 1'b0;

endmodule

// File: tb/tb_cell_pos_fetch.sv
// Directed bench for cell_pos_fetch with a two-cycle cell memory model
// and an expected-result queue consumed by an output monitor.
module tb_cell_pos_fetch;

  localparam int DW = 96;
  localparam int AW = 8;
  localparam int PN = 220;

  logic          clk = 1'b0;
  logic          rst, start, busy, done, mem_rden, out_valid, out_ready, out_last, count_err;
  logic [AW-1:0] mem_addr, out_pid, particle_count;
  logic [DW-1:0] mem_q, out_pos;

  always #5 clk = ~clk;

  cell_pos_fetch #(
    .DATA_WIDTH   (DW),
    .ADDR_WIDTH   (AW),
    .PARTICLE_NUM (PN)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .busy           (busy),
    .done           (done),
    .mem_addr       (mem_addr),
    .mem_rden       (mem_rden),
    .mem_q          (mem_q),
    .out_pos        (out_pos),
    .out_pid        (out_pid),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_last       (out_last),
    .particle_count (particle_count),
    .count_err      (count_err)
  );

  typedef struct packed {
    logic [AW-1:0] pid;
    logic [DW-1:0] pos;
    logic          last;
  } exp_t;

  exp_t          sb[$];
  logic [AW-1:0] rd_log[$];
  logic [DW-1:0] cell_mem [256];
  logic [DW-1:0] q_d1;

  int tests = 0;
  int fails = 0;
  int done_cnt, valid_cnt, pop_cnt, outstanding, max_out;
  bit stalled;
  logic [AW+DW+1:0] held;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Cell memory: two-cycle registered read.
  always @(posedge clk) begin
    if (mem_rden === 1'b1) q_d1 <= cell_mem[mem_addr];
    mem_q <= q_d1;
  end

  // Output / read-port monitor.
  always @(negedge clk) begin
    exp_t e;
    if (mem_rden === 1'b1) begin
      rd_log.push_back(mem_addr);
      if (mem_addr != '0) begin
        outstanding++;
        if (outstanding > max_out) max_out = outstanding;
      end
    end
    if (done === 1'b1) done_cnt++;
    if (out_valid === 1'b1) valid_cnt++;
    if (stalled) check("stall_hold", 128'({out_valid, out_last, out_pid, out_pos}), 128'(held));
    stalled = (out_valid === 1'b1) && (out_ready === 1'b0);
    held    = {out_valid, out_last, out_pid, out_pos};
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      pop_cnt++;
      outstanding--;
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $error("FAIL unexpected_pop observed_pid=%0d expected=none", out_pid);
      end else begin
        e = sb.pop_front();
        check("pop_pid", 128'(out_pid), 128'(e.pid));
        check("pop_pos", 128'(out_pos), 128'(e.pos));
        check("pop_last", 128'(out_last), 128'(e.last));
      end
    end
  end

  task automatic prep();
    done_cnt = 0; valid_cnt = 0; pop_cnt = 0; outstanding = 0; max_out = 0;
    stalled = 1'b0;
    rd_log.delete();
  endtask

  task automatic push_expected(input int n);
    for (int p = 1; p <= n; p++) begin
      exp_t e;
      e.pid  = AW'(p);
      e.pos  = cell_mem[p];
      e.last = (p == n);
      sb.push_back(e);
    end
  endtask

  // Caller raises start beforehand; runs until busy falls or budget expires.
  // ready_mode 1 cycles out_ready through 1,0,0,1. restart pulses start at
  // loop indices restart_a/restart_b.
  task automatic run_sweep(input int budget, input bit ready_mode, input int restart_a,
                           input int restart_b, output int first_valid);
    bit fin = 1'b0;
    first_valid = -1;
    for (int i = 0; i < budget && !fin; i++) begin
      @(posedge clk); #1;
      start     = (i == restart_a) || (i == restart_b);
      out_ready = ready_mode ? ((i % 4 == 0) || (i % 4 == 3)) : 1'b1;
      if (out_valid === 1'b1 && first_valid < 0) first_valid = i + 1;
      if (busy === 1'b0) fin = 1'b1;
    end
    start     = 1'b0;
    out_ready = 1'b1;
    check("sweep_finished", 128'(fin), 128'(1));
  endtask

  task automatic check_reads(input string tag, input int n);
    check({tag, "_rd_count"}, 128'(rd_log.size()), 128'(n + 1));
    for (int k = 0; k < rd_log.size() && k <= n; k++)
      check({tag, "_rd_addr"}, 128'(rd_log[k]), 128'(k));
  endtask

  initial begin
    int fv;
    bit found;
    rst = 1'b1; start = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 256; i++)
      cell_mem[i] = {32'(i) ^ 32'h5A5A_0000, 32'(i * 7 + 1), 32'(i)};
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", 128'({busy, done, mem_rden, mem_addr, out_valid, out_last,
                                 out_pos, out_pid, particle_count, count_err}), 128'(0));
    rst = 1'b0;

    // N=3, ready held high
    cell_mem[0] = 96'd3;
    prep(); push_expected(3);
    start = 1'b1;
    run_sweep(100, 1'b0, -1, -1, fv);
    check("n3_latency", 128'(fv), 128'(7));
    check("n3_done_once", 128'(done_cnt), 128'(1));
    check("n3_pops", 128'(pop_cnt), 128'(3));
    check("n3_sb_empty", 128'(sb.size()), 128'(0));
    check("n3_count", 128'(particle_count), 128'(3));
    check("n3_err", 128'(count_err), 128'(0));
    check_reads("n3", 3);

    // N=0
    cell_mem[0] = 96'd0;
    prep();
    start = 1'b1;
    run_sweep(50, 1'b0, -1, -1, fv);
    check("n0_no_valid", 128'(valid_cnt), 128'(0));
    check("n0_done_once", 128'(done_cnt), 128'(1));
    check("n0_busy", 128'(busy), 128'(0));
    check_reads("n0", 0);

    // N=10, ready toggling 1,0,0,1
    cell_mem[0] = 96'd10;
    prep(); push_expected(10);
    start = 1'b1;
    run_sweep(300, 1'b1, -1, -1, fv);
    check("n10_pops", 128'(pop_cnt), 128'(10));
    check("n10_sb_empty", 128'(sb.size()), 128'(0));
    check("n10_max_outstanding_le4", 128'(max_out <= 4), 128'(1));
    check("n10_done_once", 128'(done_cnt), 128'(1));
    check_reads("n10", 10);

    // Stored count above capacity
    cell_mem[0] = 96'd250;
    prep(); push_expected(PN - 1);
    start = 1'b1;
    run_sweep(2000, 1'b0, -1, -1, fv);
    check("ovf_count", 128'(particle_count), 128'(PN - 1));
    check("ovf_err", 128'(count_err), 128'(1));
    check("ovf_pops", 128'(pop_cnt), 128'(PN - 1));
    check("ovf_sb_empty", 128'(sb.size()), 128'(0));

    // Reset while streaming at pid 5
    cell_mem[0] = 96'd8;
    prep(); push_expected(8);
    start = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (out_valid === 1'b1 && out_pid === AW'(5)) found = 1'b1;
    end
    check("abort_reached_pid5", 128'(found), 128'(1));
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_outputs_zero", 128'({busy, done, mem_rden, mem_addr, out_valid, out_last,
                                      out_pos, out_pid, particle_count, count_err}), 128'(0));
    rst = 1'b0;
    sb.delete();
    repeat (4) @(posedge clk);
    #1;
    cell_mem[0] = 96'd2;
    prep(); push_expected(2);
    start = 1'b1;
    run_sweep(100, 1'b0, -1, -1, fv);
    check("after_abort_pops", 128'(pop_cnt), 128'(2));
    check("after_abort_sb_empty", 128'(sb.size()), 128'(0));
    check_reads("after_abort", 2);

    // start pulses while busy are ignored
    cell_mem[0] = 96'd3;
    prep(); push_expected(3);
    start = 1'b1;
    run_sweep(100, 1'b0, 2, 5, fv);
    repeat (3) @(posedge clk);
    #1;
    check("restart_done_once", 128'(done_cnt), 128'(1));
    check("restart_pops", 128'(pop_cnt), 128'(3));
    check("restart_busy_idle", 128'(busy), 128'(0));
    check_reads("restart", 3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
